// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: walks a 2-input gate through all four input vectors and checks it against a truth table
module gate_truth_table_checker #(
    parameter logic [3:0] TRUTH  = 4'b1000,
    parameter int         SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_o,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic       pass,
    output logic [3:0] mismatch
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [7:0] LAST = 8'(SETTLE - 1);
    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] acc_q, acc_d, mismatch_q, mismatch_d;
    logic       pass_q, pass_d, rv_q, rv_d;
    logic       hit, fail;
    assign hit          = cnt_q == LAST;
    assign fail         = dut_o != TRUTH[idx_q];
    assign busy         = state_q == RUN;
    assign done         = state_q == DONE;
    assign dut_a        = busy & idx_q[1];
    assign dut_b        = busy & idx_q[0];
    assign result_valid = rv_q;
    assign pass         = pass_q;
    assign mismatch     = mismatch_q;
    // next state: accept start when idle/done, sample the gate on the last settle cycle, publish results on leaving RUN
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        rv_d       = rv_q;
        if (state_q == RUN) begin
            if (hit) begin
                acc_d = acc_q | (4'(fail) << idx_q);
                cnt_d = '0;
                if (idx_q == 2'd3) begin
                    state_d    = DONE;
                    mismatch_d = acc_d;
                    pass_d     = acc_d == 4'b0000;
                    rv_d       = 1'b1;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (start) begin
            state_d = RUN;
            idx_d   = '0;
            cnt_d   = '0;
            acc_d   = '0;
            rv_d    = 1'b0;
        end else begin
            state_d = IDLE;
        end
    end
    // state and result registers with synchronous reset that abandons any run in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
            rv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
            rv_q       <= rv_d;
        end
    end
endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb_gate_truth_table_checker: directed vector checks of the gate truth-table checker
module tb_gate_truth_table_checker;
    logic       clk = 0, rst = 1, start1 = 0, start3 = 0;
    logic [1:0] sel = 0;
    logic       a1, b1, o1, busy1, done1, rv1, pass1;
    logic       a3, b3, o3, busy3, done3, rv3, pass3;
    logic [3:0] mm1, mm3;
    int         errors = 0, checks = 0;
    typedef struct {logic [1:0] sel; logic pass; logic [3:0] mm;} vec_t;
    vec_t       vecs[4];
    logic       prev_pass, done_seen;

    always #5 clk = ~clk;

    assign o1 = sel == 2'd0 ? (a1 & b1) : sel == 2'd1 ? (a1 | b1) : sel == 2'd2 ? 1'b0 : 1'b1;
    assign o3 = a3 & b3;

    gate_truth_table_checker u1 (
        .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1), .dut_o(o1),
        .busy(busy1), .done(done1), .result_valid(rv1), .pass(pass1), .mismatch(mm1)
    );

    gate_truth_table_checker #(.TRUTH(4'b1000), .SETTLE(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .dut_a(a3), .dut_b(b3), .dut_o(o3),
        .busy(busy3), .done(done3), .result_valid(rv3), .pass(pass3), .mismatch(mm3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{2'd0, 1'b1, 4'b0000};
        vecs[1] = '{2'd1, 1'b0, 4'b0110};
        vecs[2] = '{2'd2, 1'b0, 4'b1000};
        vecs[3] = '{2'd3, 1'b0, 4'b0111};
        tick();
        tick();
        chk("reset_outs1", {busy1, done1, rv1, pass1, mm1}, 8'h00);
        chk("reset_ab1", {a1, b1}, 8'h0);
        chk("reset_outs3", {busy3, done3, rv3, pass3, mm3}, 8'h00);
        rst = 0;
        tick();
        prev_pass = 1'b0;
        for (int v = 0; v < 4; v++) begin
            sel = vecs[v].sel;
            start1 = 1;
            tick();
            start1 = 0;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("vec%0d_ab%0d", v, k), {a1, b1}, 8'(k));
                chk($sformatf("vec%0d_busy%0d", v, k), {busy1, done1}, 8'b10);
                if (k == 0) chk($sformatf("vec%0d_stale", v), {rv1, pass1}, {7'd0, prev_pass});
                tick();
            end
            chk($sformatf("vec%0d_done", v), {busy1, done1, rv1, a1, b1}, 8'b01100);
            chk($sformatf("vec%0d_pass", v), pass1, vecs[v].pass);
            chk($sformatf("vec%0d_mm", v), mm1, vecs[v].mm);
            tick();
            chk($sformatf("vec%0d_idle", v), {busy1, done1, rv1}, 8'b001);
            chk($sformatf("vec%0d_hold", v), {pass1, mm1}, {vecs[v].pass, vecs[v].mm});
            prev_pass = vecs[v].pass;
        end
        start3 = 1;
        tick();
        start3 = 0;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("s3_ab%0d", c), {a3, b3}, 8'(c / 3));
            chk($sformatf("s3_busy%0d", c), {busy3, done3}, 8'b10);
            start3 = c == 4;
            tick();
        end
        start3 = 0;
        chk("s3_done", {busy3, done3, rv3, pass3, mm3}, 8'b01110000);
        tick();
        chk("s3_idle", {busy3, done3, rv3}, 8'b001);
        sel = 0;
        start1 = 1;
        tick();
        start1 = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mid", {busy1, done1, rv1, pass1, mm1, a1, b1}, 8'h00);
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            done_seen |= done1;
            tick();
        end
        chk("rst_no_done", done_seen, 1'b0);
        start1 = 1;
        tick();
        for (int t = 0; t < 15; t++) begin
            chk($sformatf("b2b_done%0d", t), done1, (t % 5) == 4);
            chk($sformatf("b2b_rv%0d", t), rv1, (t % 5) == 4);
            if ((t % 5) == 4) chk($sformatf("b2b_pass%0d", t), {pass1, mm1}, 8'h10);
            tick();
        end
        start1 = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gate_truth_table_checker.md
# gate_truth_table_checker

Self-checking stimulus stage that sits directly upstream of a 2-input combinational gate under test, such as the mux-built AND gate. It drives the gate's `a`/`b` inputs through all four input combinations and waits a programmable settle time per vector. It samples the gate output, compares it against a parameterised truth table, and reports a per-vector mismatch mask and an overall pass flag. This lets the gate exercises be verified on hardware as well as in simulation.

## Interface
Parameters:
- `TRUTH`, default `4'b1000`: expected gate output; bit `k` is the expected `o` for `{a,b} = k`. The default is AND.
- `SETTLE`, default `1`: cycles each vector is held before sampling. Legal range is 1..255.

Ports:
- `clk`, input, 1: sole clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a run; sampled only when `busy = 0`.
- `dut_a`, output, 1: drives gate input `a`.
- `dut_b`, output, 1: drives gate input `b`.
- `dut_o`, input, 1: gate output under test.
- `busy`, output, 1: high while a run is in progress.
- `done`, output, 1: one-cycle pulse when a run completes.
- `result_valid`, output, 1: high when `pass`/`mismatch` hold results of a completed run.
- `pass`, output, 1: 1 when the last completed run had no mismatches.
- `mismatch`, output, 4: bit `k` is set if vector `k` failed in the last completed run.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:** `dut_a = dut_b = 0`, `busy = 0`.
  - `start = 1` → load vector index 0, clear the settle counter and the internal mismatch accumulator, clear `result_valid`, go to RUN.
- **RUN:** `busy = 1`; `dut_a = idx[1]`, `dut_b = idx[0]`.
  - The settle counter counts 0..SETTLE-1.
  - On the edge where the counter equals SETTLE-1, sample `dut_o`. Set accumulator bit `idx` when `dut_o != TRUTH[idx]`.
  - On that same edge: if `idx < 3`, increment `idx` and clear the counter. If `idx = 3`, go to DONE.
- **DONE** (exactly one cycle): `done = 1`, `busy = 0`, `dut_a = dut_b = 0`.
  - Registered outputs: `mismatch ← accumulator`, `pass ← (accumulator == 0)`, `result_valid ← 1`.
  - The next state is IDLE, or RUN if `start = 1` in this cycle (a back-to-back run is allowed).
- `start` while `busy = 1` is ignored; it does not restart or extend the run.
- The index and settle counter are 2 and 8 bits wide respectively; neither wraps during a run.
- `pass`, `mismatch` and `result_valid` hold their values until the next accepted `start` or `rst`.
  - On an accepted `start`, only `result_valid` clears; `pass`/`mismatch` keep stale values until overwritten at DONE.
- **Reset values:**
  - State is IDLE; `dut_a = dut_b = 0`.
  - `busy = done = result_valid = pass = 0`, `mismatch = 4'b0000`.
- **Reset mid-run:** abandon the run immediately. No `done` pulse, no result update, and all outputs take their reset values on the following cycle.

## Timing
- `start` is sampled at edge E0. Vector `k` appears on `dut_a`/`dut_b` after edge E0 + k·SETTLE.
- `dut_o` for vector `k` is sampled at edge E0 + (k+1)·SETTLE. The gate has SETTLE−1 full cycles plus one clock period to settle.
- `done`, `pass`, `mismatch` and `result_valid` are valid in the cycle after edge E0 + 4·SETTLE.
  - Start-to-done latency is 4·SETTLE cycles.
- `busy` rises the cycle after E0 and falls in the DONE cycle.
- `dut_o` is treated as combinational from `dut_a`/`dut_b`. No extra pipeline stage is assumed.

## Test plan
- AND gate connected, default parameters, `start` pulsed:
  - Vectors `00,01,10,11` are driven on consecutive cycles.
  - `done` fires 4 cycles after `start` with `pass = 1`, `mismatch = 0000`, `result_valid = 1`.
- OR gate connected with `TRUTH = 4'b1000`: `pass = 0`, `mismatch = 0110`.
- `dut_o` tied to 0 with `TRUTH = 4'b1000`: `mismatch = 1000`. `dut_o` tied to 1: `mismatch = 0111`.
- `SETTLE = 3`, AND gate:
  - Each vector is held exactly 3 cycles.
  - `done` fires 12 cycles after `start`.
  - `start` re-pulsed at cycle 5 is ignored, and `done` still fires at 12.
- `rst` asserted at cycle 2 of a run: the next cycle shows `busy = 0`, `dut_a = dut_b = 0`, `result_valid = 0`, `mismatch = 0000`, and no `done` ever follows.
- `start` held high continuously: back-to-back runs occur with `done` every 5 cycles (4 RUN + 1 DONE, SETTLE = 1). `result_valid` clears in the cycle after each DONE.
